// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_pkg
// Brief    : State encoding, response codes and retry limit for i2c_reg_seq.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

  localparam int c_state_w = 3;

  localparam logic [c_state_w-1:0] c_st_idle      = 3'd0;
  localparam logic [c_state_w-1:0] c_st_reg_byte  = 3'd1;
  localparam logic [c_state_w-1:0] c_st_data_byte = 3'd2;
  localparam logic [c_state_w-1:0] c_st_stop_wait = 3'd3;
  localparam logic [c_state_w-1:0] c_st_resp      = 3'd4;

  localparam logic [1:0] c_status_ok      = 2'b00;
  localparam logic [1:0] c_status_nack    = 2'b01;
  localparam logic [1:0] c_status_timeout = 2'b10;

  // Extra attempts after the first NACK when retry support is built in.
  localparam int c_retry_limit = 3;

endpackage
`default_nettype wire

// File: rtl/i2c_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_timeout
// Brief    : Clearable phase counter that saturates at TIMEOUT_CYCLES-1.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_seq
// Brief    : Register read/write sequencer on top of an I2C byte master.
//            Define I2C_SEQ_RETRY_EN to retry NACKed transfers.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_dev_addr,
  input  logic [DATA_W-1:0] req_reg_addr,
  input  logic              req_rw,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              m_enable,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_data_wr,
  input  logic              m_busy,
  input  logic              m_ack_error,
  input  logic [7:0]        m_data_rd
);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_next;
  logic [6:0]           r_dev_addr;
  logic [DATA_W-1:0]    r_reg_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rw;
  logic [1:0]           r_status;
  logic                 r_busy_q;
  logic                 r_busy_qq;
  logic                 r_accepted;

  logic w_rise, w_fall, w_done, w_accept, w_stop_done, w_expired, w_clear;
  logic w_wait_phase, w_byte_phase, w_phase_ok, w_nack_evt, w_timeout_evt;
  logic w_retry;

  // Edges come from the registered copies so the master is sampled once per cycle.
  assign w_rise       = r_busy_q & ~r_busy_qq;
  assign w_fall       = ~r_busy_q & r_busy_qq;
  // A fall only completes a byte once a rise has been seen in an earlier cycle.
  assign w_done       = w_fall & r_accepted;
  assign w_stop_done  = ~r_busy_q & ~r_busy_qq;
  assign w_accept     = req_valid & req_ready;
  assign w_byte_phase = (r_state == c_st_reg_byte) || (r_state == c_st_data_byte);
  assign w_wait_phase = w_byte_phase || (r_state == c_st_stop_wait);
  assign w_phase_ok   = w_byte_phase ? w_done : w_stop_done;
  assign w_nack_evt   = w_byte_phase & w_done & m_ack_error;
  assign w_timeout_evt = w_wait_phase & w_expired & ~w_phase_ok;
  assign w_clear      = (w_state_next != r_state) | w_rise | w_fall;

`ifdef I2C_SEQ_RETRY_EN
  logic [1:0] r_retry_cnt;

  assign w_retry = (r_state == c_st_stop_wait) && w_stop_done &&
                   (r_status == c_status_nack) && (r_retry_cnt < 2'(c_retry_limit));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retry_cnt <= 2'd0;
    end else if (w_accept) begin
      r_retry_cnt <= 2'd0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + 2'd1;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  i2c_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) w_state_next = c_st_reg_byte;
      end
      c_st_reg_byte: begin
        if (w_done)             w_state_next = m_ack_error ? c_st_stop_wait : c_st_data_byte;
        else if (w_timeout_evt) w_state_next = c_st_resp;
      end
      c_st_data_byte: begin
        if (w_done)             w_state_next = c_st_stop_wait;
        else if (w_timeout_evt) w_state_next = c_st_resp;
      end
      c_st_stop_wait: begin
        if (w_stop_done)        w_state_next = w_retry ? c_st_reg_byte : c_st_resp;
        else if (w_timeout_evt) w_state_next = c_st_resp;
      end
      c_st_resp:  w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    m_enable  = 1'b0;
    m_rw      = 1'b0;
    m_data_wr = 8'h00;
    case (r_state)
      c_st_idle:      req_ready = rst;
      c_st_reg_byte: begin
        m_enable  = 1'b1;
        m_data_wr = 8'(r_reg_addr);
      end
      c_st_data_byte: begin
        m_enable  = 1'b1;
        m_rw      = r_rw;
        m_data_wr = 8'(r_wdata);
      end
      c_st_resp:      rsp_valid = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dev_addr <= 7'd0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rw       <= 1'b0;
      r_status   <= c_status_ok;
      r_busy_q   <= 1'b0;
      r_busy_qq  <= 1'b0;
      r_accepted <= 1'b0;
    end else begin
      r_busy_q  <= m_busy;
      r_busy_qq <= r_busy_q;
      if (w_state_next != r_state) r_accepted <= 1'b0;
      else if (w_rise)             r_accepted <= 1'b1;

      if (w_accept) begin
        r_dev_addr <= req_dev_addr;
        r_reg_addr <= req_reg_addr;
        r_wdata    <= req_wdata;
        r_rw       <= req_rw;
        r_status   <= c_status_ok;
      end else if (w_nack_evt) begin
        r_status <= c_status_nack;
      end else if (w_timeout_evt) begin
        r_status <= c_status_timeout;
      end else if (w_retry) begin
        r_status <= c_status_ok;
      end

      if ((r_state == c_st_data_byte) && w_done && !m_ack_error && r_rw) begin
        r_rdata <= DATA_W'(m_data_rd);
      end
    end
  end

  assign m_addr     = r_dev_addr;
  assign rsp_status = r_status;
  assign rsp_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_seq
// Brief    : Directed self-checking bench with a behavioural I2C byte master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_seq;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int DATA_W         = 8;
`ifdef I2C_SEQ_RETRY_EN
  localparam int c_exp_attempts = 4;
`else
  localparam int c_exp_attempts = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [6:0]        req_dev_addr = 7'd0;
  logic [DATA_W-1:0] req_reg_addr = '0;
  logic              req_rw = 1'b0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_rdata;
  logic              m_enable;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [7:0]        m_data_wr;
  logic              m_busy = 1'b0;
  logic              m_ack_error = 1'b0;
  logic [7:0]        m_data_rd = 8'h00;

  int errors = 0;
  int checks = 0;

  logic       model_on = 1'b1;
  int         nack_left = 0;
  logic [7:0] model_rdata = 8'h00;
  int         byte_cnt = 0;
  logic [6:0] log_addr [16];
  logic       log_rw   [16];
  logic [7:0] log_data [16];

  always #5 clk = ~clk;

  i2c_reg_seq #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .DATA_W        (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dev_addr(req_dev_addr),
    .req_reg_addr(req_reg_addr),
    .req_rw      (req_rw),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_rdata   (rsp_rdata),
    .m_enable    (m_enable),
    .m_addr      (m_addr),
    .m_rw        (m_rw),
    .m_data_wr   (m_data_wr),
    .m_busy      (m_busy),
    .m_ack_error (m_ack_error),
    .m_data_rd   (m_data_rd)
  );

  // Byte master: latch command, busy for 3 cycles, then report ack and read data.
  initial begin
    forever begin
      @(negedge clk);
      if (m_enable && model_on) begin
        if (byte_cnt < 16) begin
          log_addr[byte_cnt] = m_addr;
          log_rw[byte_cnt]   = m_rw;
          log_data[byte_cnt] = m_data_wr;
        end
        byte_cnt = byte_cnt + 1;
        @(negedge clk);
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        m_busy      = 1'b0;
        m_ack_error = (nack_left > 0);
        if (nack_left > 0) nack_left = nack_left - 1;
        m_data_rd   = model_rdata;
        @(negedge clk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue_req(input logic [6:0] dev, input logic [7:0] reg_a,
                           input logic rw, input logic [7:0] wdata);
    @(negedge clk);
    req_dev_addr = dev;
    req_reg_addr = reg_a;
    req_rw       = rw;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  task automatic collect(input int cycles, output int pulses,
                         output logic [1:0] st, output logic [7:0] rd);
    pulses = 0;
    st     = 2'bxx;
    rd     = 8'hxx;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        pulses = pulses + 1;
        st     = rsp_status;
        rd     = rsp_rdata;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", rsp_status); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
    checks++; if ({m_enable, m_rw, m_addr, m_data_wr} !== 17'd0) begin errors++;
      $display("FAIL reset_master_cmd: got en=%b rw=%b addr=%h data=%h expected all 0", m_enable, m_rw, m_addr, m_data_wr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_write();
    int p; logic [1:0] st; logic [7:0] rd;
    byte_cnt = 0; nack_left = 0; model_rdata = 8'h00;
    issue_req(7'h50, 8'h10, 1'b0, 8'hA5);
    collect(60, p, st, rd);
    checks++; if (p !== 1) begin errors++; $display("FAIL write_rsp_count: got %0d expected 1", p); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL write_status: got %b expected 00", st); end
    checks++; if (byte_cnt !== 2) begin errors++; $display("FAIL write_bytes: got %0d expected 2", byte_cnt); end
    checks++; if ({log_addr[0], log_rw[0], log_data[0]} !== {7'h50, 1'b0, 8'h10}) begin errors++;
      $display("FAIL write_byte0: got %h/%b/%h expected 50/0/10", log_addr[0], log_rw[0], log_data[0]); end
    checks++; if ({log_addr[1], log_rw[1], log_data[1]} !== {7'h50, 1'b0, 8'hA5}) begin errors++;
      $display("FAIL write_byte1: got %h/%b/%h expected 50/0/a5", log_addr[1], log_rw[1], log_data[1]); end
    checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL write_enable_drop: got %b expected 0", m_enable); end
  endtask

  task automatic test_read();
    int p; logic [1:0] st; logic [7:0] rd;
    byte_cnt = 0; model_rdata = 8'h71;
    issue_req(7'h68, 8'h75, 1'b1, 8'h00);
    collect(60, p, st, rd);
    checks++; if (p !== 1) begin errors++; $display("FAIL read_rsp_count: got %0d expected 1", p); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL read_status: got %b expected 00", st); end
    checks++; if (rd !== 8'h71) begin errors++; $display("FAIL read_rdata: got %h expected 71", rd); end
    checks++; if ({log_addr[0], log_rw[0], log_data[0]} !== {7'h68, 1'b0, 8'h75}) begin errors++;
      $display("FAIL read_byte0: got %h/%b/%h expected 68/0/75", log_addr[0], log_rw[0], log_data[0]); end
    checks++; if ({log_addr[1], log_rw[1]} !== {7'h68, 1'b1}) begin errors++;
      $display("FAIL read_byte1_rw: got %h/%b expected 68/1", log_addr[1], log_rw[1]); end
  endtask

  task automatic test_nack();
    int p; int bad; logic [1:0] st; logic [7:0] rd;
    byte_cnt = 0; nack_left = 100; model_rdata = 8'hEE;
    issue_req(7'h50, 8'h22, 1'b0, 8'h33);
    collect(150, p, st, rd);
    nack_left = 0;
    checks++; if (p !== 1) begin errors++; $display("FAIL nack_rsp_count: got %0d expected 1", p); end
    checks++; if (st !== 2'b01) begin errors++; $display("FAIL nack_status: got %b expected 01", st); end
    checks++; if (byte_cnt !== c_exp_attempts) begin errors++;
      $display("FAIL nack_attempts: got %0d expected %0d", byte_cnt, c_exp_attempts); end
    bad = 0;
    for (int i = 0; i < byte_cnt && i < 16; i++)
      if ({log_rw[i], log_data[i]} !== {1'b0, 8'h22}) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL nack_no_data_byte: got %0d non-register bytes expected 0", bad); end
    checks++; if (rd !== 8'h71) begin errors++; $display("FAIL nack_rdata_hold: got %h expected 71", rd); end
  endtask

  task automatic test_timeout();
    model_on = 1'b0; byte_cnt = 0;
    issue_req(7'h50, 8'h10, 1'b0, 8'hA5);
    checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL tmo_enable_start: got %b expected 1", m_enable); end
    repeat (15) @(negedge clk);
    checks++; if ({m_enable, rsp_valid} !== 2'b10) begin errors++;
      $display("FAIL tmo_cycle15: got en=%b rsp=%b expected en=1 rsp=0", m_enable, rsp_valid); end
    @(negedge clk);
    checks++; if ({m_enable, rsp_valid, rsp_status} !== 4'b0110) begin errors++;
      $display("FAIL tmo_cycle16: got en=%b rsp=%b st=%b expected en=0 rsp=1 st=10", m_enable, rsp_valid, rsp_status); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_rsp_one_cycle: got %b expected 0", rsp_valid); end
    model_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int p; int w; logic [1:0] st; logic [7:0] rd;
    byte_cnt = 0;
    issue_req(7'h50, 8'h10, 1'b0, 8'hA5);
    w = 0;
    while (byte_cnt < 2 && w < 40) begin @(negedge clk); w++; end
    checks++; if (byte_cnt !== 2) begin errors++; $display("FAIL rstmid_reach_data: got %0d bytes expected 2", byte_cnt); end
    checks++; if (m_enable !== 1'b1) begin errors++; $display("FAIL rstmid_enable_before: got %b expected 1", m_enable); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({m_enable, req_ready} !== 2'b00) begin errors++;
      $display("FAIL rstmid_enable_drop: got en=%b ready=%b expected 0/0", m_enable, req_ready); end
    rst = 1'b1;
    collect(40, p, st, rd);
    checks++; if (p !== 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", p); end
    byte_cnt = 0;
    issue_req(7'h51, 8'h12, 1'b0, 8'h5A);
    collect(60, p, st, rd);
    checks++; if ({p[1:0], st} !== {2'd1, 2'b00}) begin errors++;
      $display("FAIL rstmid_recover: got pulses=%0d st=%b expected 1/00", p, st); end
    checks++; if ({log_addr[1], log_data[1]} !== {7'h51, 8'h5A}) begin errors++;
      $display("FAIL rstmid_recover_byte: got %h/%h expected 51/5a", log_addr[1], log_data[1]); end
  endtask

  task automatic test_back_to_back();
    int p; logic [1:0] st; logic [7:0] rd;
    byte_cnt = 0;
    issue_req(7'h50, 8'h10, 1'b0, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_dev_addr = 7'h11; req_reg_addr = 8'h99; req_rw = 1'b1; req_wdata = 8'h77;
      req_valid = 1'b1;
      if (i == 0) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", req_ready); end
      end
    end
    req_valid = 1'b0;
    collect(60, p, st, rd);
    checks++; if (p !== 1) begin errors++; $display("FAIL ignore_rsp_count: got %0d expected 1", p); end
    checks++; if ({log_addr[1], log_rw[1], log_data[1]} !== {7'h50, 1'b0, 8'hA5}) begin errors++;
      $display("FAIL ignore_latched: got %h/%b/%h expected 50/0/a5", log_addr[1], log_rw[1], log_data[1]); end
    checks++; if (byte_cnt !== 2) begin errors++; $display("FAIL ignore_bytes: got %0d expected 2", byte_cnt); end
    byte_cnt = 0; model_rdata = 8'h5C;
    issue_req(7'h68, 8'h75, 1'b1, 8'h00);
    collect(60, p, st, rd);
    checks++; if ({p[1:0], st, rd} !== {2'd1, 2'b00, 8'h5C}) begin errors++;
      $display("FAIL b2b_read: got pulses=%0d st=%b rd=%h expected 1/00/5c", p, st, rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
